// File: rtl/avg_filter_pkg.sv
// Shared constants and helpers for the multi-mode period averager.
// Mode codes and accumulator width derivation used by avg_filter_multi.
package avg_filter_pkg;

   localparam int AVG_MODE_BLOCK = 0;
   localparam int AVG_MODE_SLIDE = 1;

   function automatic int avg_acc_width(input int data_w, input int log2_n);
      return data_w + log2_n;
   endfunction

endpackage

// File: rtl/avg_ring_buf.sv
// Sample history for the sliding average: registered write, asynchronous read.
// Reading the write address returns the sample being overwritten this cycle.
module avg_ring_buf #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   assign rdata_o = mem_q[addr_i];

   // Storage write; contents are never reset, fill tracking lives in the parent
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/avg_filter_multi.sv
// Averages the period_measure count stream over 2^LOG2_N samples, either
// decimating (block) or as a moving average, with optional half-up rounding.
module avg_filter_multi
   import avg_filter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LOG2_N = 4,
   parameter int MODE   = 0,
   parameter int ROUND  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic [DATA_W-1:0] filter_out,
   output logic              filter_valid,
   output logic              window_full,
   output logic [LOG2_N:0]   fill_count
);

   localparam int ACC_W = avg_acc_width(DATA_W, LOG2_N);
   localparam int N     = 2**LOG2_N;
   localparam logic [LOG2_N:0]   FILL_FULL = (LOG2_N+1)'(N);
   localparam logic [LOG2_N:0]   FILL_LAST = (LOG2_N+1)'(N-1);
   localparam logic [LOG2_N:0]   FILL_ONE  = (LOG2_N+1)'(1);
   localparam logic [LOG2_N-1:0] PTR_ONE   = LOG2_N'(1);
   localparam logic [ACC_W:0]    RND_ADD   =
      (ROUND != 0) ? ((ACC_W+1)'(1) << (LOG2_N-1)) : (ACC_W+1)'(0);

   logic [ACC_W-1:0]  sum_q, sum_d;
   logic [LOG2_N:0]   fill_q, fill_d;
   logic [LOG2_N-1:0] ptr_q, ptr_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              valid_q, valid_d;
   logic              full_q, full_d;

   logic [DATA_W-1:0] oldest_s;
   logic [ACC_W:0]    sum_in_s;
   logic [ACC_W:0]    sum_slide_s;
   logic [ACC_W:0]    sum_next_s;
   logic [ACC_W:0]    rnd_s;
   logic [DATA_W-1:0] avg_s;

   generate
      if (MODE == AVG_MODE_SLIDE) begin : g_ring
         avg_ring_buf #(
            .DATA_W (DATA_W),
            .ADDR_W (LOG2_N)
         ) u_ring (
            .clk     (clk),
            .we_i    (data_valid && !clear && !reset),
            .addr_i  (ptr_q),
            .wdata_i (data_in),
            .rdata_o (oldest_s)
         );
      end else begin : g_no_ring
         assign oldest_s = {DATA_W{1'b0}};
      end
   endgenerate

   // One extra bit so a full window plus the incoming sample cannot wrap
   assign sum_in_s    = {1'b0, sum_q} + (ACC_W+1)'(data_in);
   assign sum_slide_s = sum_in_s - (ACC_W+1)'(oldest_s);

   // Window sum including the current sample, and its scaled average
   always_comb begin
      if ((MODE == AVG_MODE_SLIDE) && (fill_q == FILL_FULL)) begin
         sum_next_s = sum_slide_s;
      end else begin
         sum_next_s = sum_in_s;
      end
      rnd_s = sum_next_s + RND_ADD;
      avg_s = DATA_W'(rnd_s >> LOG2_N);
   end

   // Next-state for accumulation, fill tracking and output update
   always_comb begin
      sum_d   = sum_q;
      fill_d  = fill_q;
      ptr_d   = ptr_q;
      out_d   = out_q;
      valid_d = 1'b0;
      full_d  = (MODE == AVG_MODE_SLIDE) ? full_q : 1'b0;
      if (clear) begin
         sum_d  = {ACC_W{1'b0}};
         fill_d = {(LOG2_N+1){1'b0}};
         ptr_d  = {LOG2_N{1'b0}};
         full_d = 1'b0;
      end else if (data_valid) begin
         if (MODE == AVG_MODE_SLIDE) begin
            ptr_d = ptr_q + PTR_ONE;
            sum_d = sum_next_s[ACC_W-1:0];
            if (fill_q == FILL_FULL) begin
               out_d   = avg_s;
               valid_d = 1'b1;
               full_d  = 1'b1;
            end else begin
               fill_d = fill_q + FILL_ONE;
               if (fill_q == FILL_LAST) begin
                  out_d   = avg_s;
                  valid_d = 1'b1;
                  full_d  = 1'b1;
               end else begin
                  valid_d = 1'b0;
               end
            end
         end else begin
            if (fill_q == FILL_LAST) begin
               out_d   = avg_s;
               valid_d = 1'b1;
               full_d  = 1'b1;
               sum_d   = {ACC_W{1'b0}};
               fill_d  = {(LOG2_N+1){1'b0}};
            end else begin
               sum_d  = sum_next_s[ACC_W-1:0];
               fill_d = fill_q + FILL_ONE;
            end
         end
      end else begin
         valid_d = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q   <= {ACC_W{1'b0}};
         fill_q  <= {(LOG2_N+1){1'b0}};
         ptr_q   <= {LOG2_N{1'b0}};
         out_q   <= {DATA_W{1'b0}};
         valid_q <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         fill_q  <= fill_d;
         ptr_q   <= ptr_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         full_q  <= full_d;
      end
   end

   assign filter_out   = out_q;
   assign filter_valid = valid_q;
   assign window_full  = full_q;
   assign fill_count   = fill_q;

endmodule

// File: tb/tb_avg_filter_multi.sv
// Bench for avg_filter_multi: five configurations share one stimulus stream and
// are checked each cycle against a queue-based window model plus literal values.
module tb_avg_filter_multi;

   localparam int NI = 5;
   localparam int P_MODE [NI] = '{0, 0, 1, 0, 1};
   localparam int P_L    [NI] = '{2, 2, 2, 4, 4};
   localparam int P_R    [NI] = '{0, 1, 0, 1, 1};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        data_valid = 1'b0;
   logic [31:0] data_in = 32'd0;

   logic [31:0] out_w   [NI];
   logic        valid_w [NI];
   logic        full_w  [NI];
   logic [4:0]  fill_w  [NI];
   logic [2:0]  fc0, fc1, fc2;
   logic [4:0]  fc3, fc4;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   avg_filter_multi #(.DATA_W(32), .LOG2_N(2), .MODE(0), .ROUND(0)) u0 (
      .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .data_valid(data_valid),
      .filter_out(out_w[0]), .filter_valid(valid_w[0]), .window_full(full_w[0]), .fill_count(fc0));
   avg_filter_multi #(.DATA_W(32), .LOG2_N(2), .MODE(0), .ROUND(1)) u1 (
      .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .data_valid(data_valid),
      .filter_out(out_w[1]), .filter_valid(valid_w[1]), .window_full(full_w[1]), .fill_count(fc1));
   avg_filter_multi #(.DATA_W(32), .LOG2_N(2), .MODE(1), .ROUND(0)) u2 (
      .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .data_valid(data_valid),
      .filter_out(out_w[2]), .filter_valid(valid_w[2]), .window_full(full_w[2]), .fill_count(fc2));
   avg_filter_multi #(.DATA_W(32), .LOG2_N(4), .MODE(0), .ROUND(1)) u3 (
      .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .data_valid(data_valid),
      .filter_out(out_w[3]), .filter_valid(valid_w[3]), .window_full(full_w[3]), .fill_count(fc3));
   avg_filter_multi #(.DATA_W(32), .LOG2_N(4), .MODE(1), .ROUND(1)) u4 (
      .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .data_valid(data_valid),
      .filter_out(out_w[4]), .filter_valid(valid_w[4]), .window_full(full_w[4]), .fill_count(fc4));

   assign fill_w[0] = {2'b00, fc0};
   assign fill_w[1] = {2'b00, fc1};
   assign fill_w[2] = {2'b00, fc2};
   assign fill_w[3] = fc3;
   assign fill_w[4] = fc4;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Reference model: the window is simply the list of samples since reset/clear
   longint unsigned win_q [NI][$];
   logic [31:0] exp_out   [NI];
   logic        exp_valid [NI];
   logic        exp_full  [NI];
   int          exp_fill  [NI];

   function automatic logic [31:0] avg_of(input int i);
      longint unsigned s;
      s = 0;
      for (int k = 0; k < win_q[i].size(); k++) s += win_q[i][k];
      if (P_R[i] != 0) s += 64'd1 << (P_L[i] - 1);
      s = s >> P_L[i];
      return s[31:0];
   endfunction

   task automatic model_step(input int i, input logic r, input logic c, input logic v, input logic [31:0] d);
      int n;
      n = 1 << P_L[i];
      if (r) begin
         win_q[i].delete();
         exp_out[i] = 32'd0; exp_valid[i] = 1'b0; exp_full[i] = 1'b0;
      end else if (c) begin
         win_q[i].delete();
         exp_valid[i] = 1'b0; exp_full[i] = 1'b0;
      end else if (v) begin
         win_q[i].push_back({32'd0, d});
         if (P_MODE[i] == 1 && win_q[i].size() > n) void'(win_q[i].pop_front());
         if (win_q[i].size() == n) begin
            exp_out[i] = avg_of(i); exp_valid[i] = 1'b1; exp_full[i] = 1'b1;
            if (P_MODE[i] == 0) win_q[i].delete();
         end else begin
            exp_valid[i] = 1'b0; exp_full[i] = 1'b0;
         end
      end else begin
         exp_valid[i] = 1'b0;
         exp_full[i] = (P_MODE[i] == 1) && (win_q[i].size() == n);
      end
      exp_fill[i] = win_q[i].size();
   endtask

   // Compare process: model advances on each edge, DUT checked 1 time unit later
   initial begin
      logic r, c, v;
      logic [31:0] d;
      forever begin
         @(posedge clk);
         r = reset; c = clear; v = data_valid; d = data_in;
         for (int i = 0; i < NI; i++) model_step(i, r, c, v, d);
         #1;
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d.filter_out", i),   out_w[i],   exp_out[i]);
            chk($sformatf("u%0d.filter_valid", i), valid_w[i], exp_valid[i]);
            chk($sformatf("u%0d.window_full", i),  full_w[i],  exp_full[i]);
            chk($sformatf("u%0d.fill_count", i),   fill_w[i],  64'(exp_fill[i]));
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] d, input logic c, input logic r);
      @(negedge clk);
      data_valid = v; data_in = d; clear = c; reset = r;
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [31:0] d);
      drive(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic slide_seq(input int gmax);
      logic [31:0] vals [7];
      logic [31:0] exps [7];
      vals = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28};
      exps = '{32'd0, 32'd0, 32'd0, 32'd10, 32'd14, 32'd18, 32'd22};
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      for (int k = 0; k < 7; k++) begin
         repeat ($urandom_range(0, gmax)) drive(1'b0, 32'd0, 1'b0, 1'b0);
         send(vals[k]);
         if (k < 3) begin
            chk("slide_fill_novalid", valid_w[2], 1'b0);
         end else begin
            chk("slide_out", out_w[2], exps[k]);
            chk("slide_valid", valid_w[2], 1'b1);
            chk("slide_full", full_w[2], 1'b1);
            chk("slide_fill", fill_w[2], 5'd4);
         end
      end
   endtask

   // Directed stimulus with hand-computed expectations
   initial begin
      int pulses;
      repeat (2) drive(1'b0, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < NI; i++) begin
         chk("reset_out", out_w[i], 32'd0);
         chk("reset_valid", valid_w[i], 1'b0);
         chk("reset_full", full_w[i], 1'b0);
         chk("reset_fill", fill_w[i], 5'd0);
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0);

      send(32'd10); send(32'd20); send(32'd30);
      chk("blk_no_early_valid", valid_w[0], 1'b0);
      send(32'd40);
      chk("blk_avg25", out_w[0], 32'd25);
      chk("blk_valid", valid_w[0], 1'b1);
      chk("blk_full_pulse", full_w[0], 1'b1);
      chk("blk_fill_wrap", fill_w[0], 5'd0);
      chk("slide_avg25", out_w[2], 32'd25);
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      chk("blk_full_drop", full_w[0], 1'b0);
      chk("blk_out_hold", out_w[0], 32'd25);

      send(32'd1); send(32'd1); send(32'd1); send(32'd2);
      chk("blk_trunc_5", out_w[0], 32'd1);
      chk("blk_round_5", out_w[1], 32'd1);
      send(32'd1); send(32'd2); send(32'd2); send(32'd2);
      chk("blk_round_7", out_w[1], 32'd2);
      chk("blk_trunc_7", out_w[0], 32'd1);

      slide_seq(0);
      slide_seq(5);

      drive(1'b0, 32'd0, 1'b0, 1'b1);
      send(32'd50); send(32'd60);
      drive(1'b1, 32'd999, 1'b1, 1'b0);
      chk("clear_fill", fill_w[2], 5'd0);
      chk("clear_valid", valid_w[2], 1'b0);
      chk("clear_full", full_w[2], 1'b0);
      repeat (4) send(32'd100);
      chk("clear_slide_out", out_w[2], 32'd100);
      chk("clear_slide_valid", valid_w[2], 1'b1);
      chk("clear_blk_out", out_w[0], 32'd100);

      drive(1'b0, 32'd0, 1'b0, 1'b1);
      repeat (16) send(32'hFFFF_FFFF);
      chk("sat_blk_out", out_w[3], 32'hFFFF_FFFF);
      chk("sat_blk_valid", valid_w[3], 1'b1);
      chk("sat_slide_out", out_w[4], 32'hFFFF_FFFF);
      chk("sat_slide_full", full_w[4], 1'b1);
      send(32'hFFFF_FFFF);
      chk("sat_slide_steady", out_w[4], 32'hFFFF_FFFF);

      drive(1'b0, 32'd0, 1'b0, 1'b1);
      repeat (3) send(32'd1000);
      chk("midfill_fill3", fill_w[3], 5'd3);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      chk("midrst_out", out_w[3], 32'd0);
      chk("midrst_fill", fill_w[3], 5'd0);
      pulses = 0;
      for (int k = 0; k < 16; k++) begin
         send(32'd7);
         if (valid_w[3] === 1'b1) pulses++;
      end
      chk("midrst_pulses", 64'(pulses), 64'd1);
      chk("midrst_out7", out_w[3], 32'd7);

      drive(1'b0, 32'd0, 1'b0, 1'b0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
